// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: circular queue that retires up to two results per cycle in
// program order, with store handshaking, branch resolution and flush.
module reorder_buffer_mc #(
    parameter int IDX_W = 3,
    parameter int CW    = 2,
    parameter int WBP   = 2
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  dp_valid,
    input  logic [31:0]           dp_pc,
    input  logic [6:0]            dp_opcode,
    input  logic [5:0]            dp_rd,
    input  logic                  dp_pred_taken,
    output logic                  dp_ready,
    output logic [IDX_W-1:0]      dp_idx,
    input  logic [IDX_W:0]        qj_idx,
    input  logic [IDX_W:0]        qk_idx,
    output logic                  qj_ready,
    output logic                  qk_ready,
    output logic [31:0]           vj,
    output logic [31:0]           vk,
    input  logic [WBP-1:0]        wb_en,
    input  logic [WBP*IDX_W-1:0]  wb_idx,
    input  logic [WBP*32-1:0]     wb_value,
    input  logic [WBP*32-1:0]     wb_next_pc,
    output logic [CW-1:0]         cm_en,
    output logic [CW*IDX_W-1:0]   cm_idx,
    output logic [CW*6-1:0]       cm_rd,
    output logic [CW*32-1:0]      cm_value,
    output logic                  st_req,
    output logic [IDX_W-1:0]      st_idx,
    input  logic                  st_ack,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic                  bp_en,
    output logic [31:0]           bp_pc,
    output logic                  bp_taken,
    output logic [IDX_W:0]        count
);

    localparam int              D     = 1 << IDX_W;
    localparam logic [IDX_W:0]  DFULL = (IDX_W+1)'(D);
    localparam logic [5:0]      NO_RD = 6'b100000;

    function automatic logic is_store(input logic [6:0] op);
        return (op >= 7'd16) && (op <= 7'd18);
    endfunction

    function automatic logic is_branch(input logic [6:0] op);
        return (op >= 7'd5) && (op <= 7'd10);
    endfunction

    function automatic logic is_jalr(input logic [6:0] op);
        return op == 7'd4;
    endfunction

    logic [D-1:0]        r_valid;
    logic [D-1:0]        r_ready;
    logic [D-1:0]        r_pred;
    logic [31:0]         r_pc    [D];
    logic [31:0]         r_value [D];
    logic [31:0]         r_npc   [D];
    logic [6:0]          r_op    [D];
    logic [5:0]          r_rd    [D];
    logic [IDX_W-1:0]    r_head;
    logic [IDX_W-1:0]    r_tail;
    logic [IDX_W:0]      r_count;

    logic [CW-1:0]       r_cm_en;
    logic [CW*IDX_W-1:0] r_cm_idx;
    logic [CW*6-1:0]     r_cm_rd;
    logic [CW*32-1:0]    r_cm_value;
    logic                r_flush;
    logic [31:0]         r_flush_pc;
    logic                r_bp_en;
    logic [31:0]         r_bp_pc;
    logic                r_bp_taken;

    logic [IDX_W-1:0]    w_head1;
    logic [IDX_W-1:0]    w_head_nxt;
    logic                w_dp_fire;
    logic                w_head_store;
    logic                w_head_br;
    logic                w_head_jalr;
    logic                w_cm0;
    logic                w_cm1;
    logic                w_bp;
    logic                w_taken;
    logic                w_flush_now;
    logic [IDX_W:0]      w_ncm;
    logic [1:0]          w_cm_vec;
    logic [2*IDX_W-1:0]  w_cm_idx;
    logic [11:0]         w_cm_rd;
    logic [63:0]         w_cm_value;

    assign w_head1      = r_head + 1'b1;
    assign dp_ready     = (r_count != DFULL) && !r_flush;
    assign dp_idx       = r_tail;
    assign w_dp_fire    = dp_valid && dp_ready && Sys_rdy;
    assign w_head_store = r_valid[r_head] && is_store(r_op[r_head]);
    assign w_head_br    = is_branch(r_op[r_head]);
    assign w_head_jalr  = is_jalr(r_op[r_head]);
    assign st_req       = w_head_store;
    assign st_idx       = r_head;

    assign w_cm0 = Sys_rdy && r_valid[r_head] &&
                   (w_head_store ? st_ack : r_ready[r_head]);
    assign w_cm1 = (CW == 2) && w_cm0 && !w_head_store && !w_head_br && !w_head_jalr &&
                   r_valid[w_head1] && r_ready[w_head1] &&
                   !is_store(r_op[w_head1]) && !is_branch(r_op[w_head1]) &&
                   !is_jalr(r_op[w_head1]);

    assign w_taken     = r_value[r_head][0];
    assign w_bp        = w_cm0 && w_head_br;
    assign w_flush_now = w_cm0 && ((w_head_br && (w_taken != r_pred[r_head])) || w_head_jalr);
    assign w_ncm       = (IDX_W+1)'(w_cm0) + (IDX_W+1)'(w_cm1);

    assign w_cm_vec   = {w_cm1, w_cm0};
    assign w_cm_idx   = {w_head1, r_head};
    assign w_cm_rd    = {r_rd[w_head1], (w_head_store ? NO_RD : r_rd[r_head])};
    assign w_cm_value = {r_value[w_head1], r_value[r_head]};

    always_comb begin
        w_head_nxt = r_head;
        if (w_cm1)
            w_head_nxt = r_head + IDX_W'(2);
        else if (w_cm0)
            w_head_nxt = w_head1;
    end

    // Operand lookup: same-cycle writeback beats the stored value; the highest port wins.
    always_comb begin
        qj_ready = qj_idx[IDX_W] || r_ready[qj_idx[IDX_W-1:0]];
        qk_ready = qk_idx[IDX_W] || r_ready[qk_idx[IDX_W-1:0]];
        vj       = r_value[qj_idx[IDX_W-1:0]];
        vk       = r_value[qk_idx[IDX_W-1:0]];
        for (int p = 0; p < WBP; p++) begin
            if (wb_en[p] && (wb_idx[p*IDX_W +: IDX_W] == qj_idx[IDX_W-1:0])) begin
                qj_ready = 1'b1;
                vj       = wb_value[p*32 +: 32];
            end
            if (wb_en[p] && (wb_idx[p*IDX_W +: IDX_W] == qk_idx[IDX_W-1:0])) begin
                qk_ready = 1'b1;
                vk       = wb_value[p*32 +: 32];
            end
        end
        if (qj_idx[IDX_W])
            vj = 32'd0;
        if (qk_idx[IDX_W])
            vk = 32'd0;
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst) begin
            r_valid    <= '0;
            r_ready    <= '0;
            r_pred     <= '0;
            for (int i = 0; i < D; i++) begin
                r_pc[i]    <= '0;
                r_value[i] <= '0;
                r_npc[i]   <= '0;
                r_op[i]    <= '0;
                r_rd[i]    <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_cm_en    <= '0;
            r_cm_idx   <= '0;
            r_cm_rd    <= '0;
            r_cm_value <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
            r_bp_en    <= 1'b0;
            r_bp_pc    <= '0;
            r_bp_taken <= 1'b0;
        end else if (Sys_rdy) begin
            r_cm_en    <= w_cm_vec[CW-1:0];
            r_cm_idx   <= w_cm_idx[CW*IDX_W-1:0];
            r_cm_rd    <= w_cm_rd[CW*6-1:0];
            r_cm_value <= w_cm_value[CW*32-1:0];
            r_bp_en    <= w_bp;
            r_flush    <= w_flush_now;
            if (w_bp) begin
                r_bp_pc    <= r_pc[r_head];
                r_bp_taken <= w_taken;
            end
            if (w_flush_now)
                r_flush_pc <= r_npc[r_head];

            if (w_flush_now) begin
                r_valid <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_cm0)
                    r_valid[r_head] <= 1'b0;
                if (w_cm1)
                    r_valid[w_head1] <= 1'b0;
                if (w_dp_fire) begin
                    r_valid[r_tail] <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_pc[r_tail]    <= dp_pc;
                    r_op[r_tail]    <= dp_opcode;
                    r_rd[r_tail]    <= dp_rd;
                    r_pred[r_tail]  <= dp_pred_taken;
                    r_tail          <= r_tail + 1'b1;
                end
                // Writebacks landing in the flush cycle belong to squashed work.
                for (int p = 0; p < WBP; p++) begin
                    if (wb_en[p] && !r_flush && r_valid[wb_idx[p*IDX_W +: IDX_W]]) begin
                        r_ready[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
                        r_value[wb_idx[p*IDX_W +: IDX_W]] <= wb_value[p*32 +: 32];
                        r_npc[wb_idx[p*IDX_W +: IDX_W]]   <= wb_next_pc[p*32 +: 32];
                    end
                end
                r_head  <= w_head_nxt;
                r_count <= r_count + (IDX_W+1)'(w_dp_fire) - w_ncm;
            end
        end
    end

    // Pulses are shown only in enabled cycles; a stall defers them rather than dropping them.
    assign cm_en    = r_cm_en & {CW{Sys_rdy}};
    assign cm_idx   = r_cm_idx;
    assign cm_rd    = r_cm_rd;
    assign cm_value = r_cm_value;
    assign flush    = r_flush & Sys_rdy;
    assign flush_pc = r_flush_pc;
    assign bp_en    = r_bp_en & Sys_rdy;
    assign bp_pc    = r_bp_pc;
    assign bp_taken = r_bp_taken;
    assign count    = r_count;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: fill, dual commit, forwarding,
// mispredict/jalr flush, store handshake, reset during flush and stall.
module tb_reorder_buffer_mc;

    localparam int IDX_W = 3;
    localparam int CW    = 2;
    localparam int WBP   = 2;

    logic                  Sys_clk;
    logic                  Sys_rst;
    logic                  Sys_rdy;
    logic                  dp_valid;
    logic [31:0]           dp_pc;
    logic [6:0]            dp_opcode;
    logic [5:0]            dp_rd;
    logic                  dp_pred_taken;
    logic                  dp_ready;
    logic [IDX_W-1:0]      dp_idx;
    logic [IDX_W:0]        qj_idx;
    logic [IDX_W:0]        qk_idx;
    logic                  qj_ready;
    logic                  qk_ready;
    logic [31:0]           vj;
    logic [31:0]           vk;
    logic [WBP-1:0]        wb_en;
    logic [WBP*IDX_W-1:0]  wb_idx;
    logic [WBP*32-1:0]     wb_value;
    logic [WBP*32-1:0]     wb_next_pc;
    logic [CW-1:0]         cm_en;
    logic [CW*IDX_W-1:0]   cm_idx;
    logic [CW*6-1:0]       cm_rd;
    logic [CW*32-1:0]      cm_value;
    logic                  st_req;
    logic [IDX_W-1:0]      st_idx;
    logic                  st_ack;
    logic                  flush;
    logic [31:0]           flush_pc;
    logic                  bp_en;
    logic [31:0]           bp_pc;
    logic                  bp_taken;
    logic [IDX_W:0]        count;

    int n_chk  = 0;
    int n_fail = 0;

    reorder_buffer_mc #(.IDX_W(IDX_W), .CW(CW), .WBP(WBP)) dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .dp_valid(dp_valid), .dp_pc(dp_pc), .dp_opcode(dp_opcode), .dp_rd(dp_rd),
        .dp_pred_taken(dp_pred_taken), .dp_ready(dp_ready), .dp_idx(dp_idx),
        .qj_idx(qj_idx), .qk_idx(qk_idx), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .vj(vj), .vk(vk),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_value(wb_value), .wb_next_pc(wb_next_pc),
        .cm_en(cm_en), .cm_idx(cm_idx), .cm_rd(cm_rd), .cm_value(cm_value),
        .st_req(st_req), .st_idx(st_idx), .st_ack(st_ack),
        .flush(flush), .flush_pc(flush_pc),
        .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .count(count)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic clr();
        dp_valid      = 1'b0;
        dp_pc         = '0;
        dp_opcode     = '0;
        dp_rd         = '0;
        dp_pred_taken = 1'b0;
        qj_idx        = 4'b1000;
        qk_idx        = 4'b1000;
        wb_en         = '0;
        wb_idx        = '0;
        wb_value      = '0;
        wb_next_pc    = '0;
        st_ack        = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        Sys_rdy = 1'b1;
        Sys_rst = 1'b0;
        step();
        Sys_rst = 1'b1;
    endtask

    task automatic disp(input logic [6:0] op, input logic [31:0] pc,
                        input logic [5:0] rd, input logic pred);
        dp_valid      = 1'b1;
        dp_opcode     = op;
        dp_pc         = pc;
        dp_rd         = rd;
        dp_pred_taken = pred;
        step();
        dp_valid      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Sys_rdy = 1'b1;
        Sys_rst = 1'b0;
        clr();
        step();
        do_reset();
        #1;
        chk("rst_count", count, 0);
        chk("rst_dp_ready", dp_ready, 1);
        chk("rst_dp_idx", dp_idx, 0);
        chk("rst_cm_en", cm_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_bp_en", bp_en, 0);
        chk("rst_st_req", st_req, 0);
        chk("rst_qj_nodep", qj_ready, 1);
        chk("rst_vj_nodep", vj, 0);

        // Fill all eight entries, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            dp_valid  = 1'b1;
            dp_opcode = 7'd0;
            dp_rd     = 6'(i);
            dp_pc     = 32'(i * 4);
            #1;
            chk("fill_dp_idx", dp_idx, i);
            step();
        end
        #1;
        chk("fill_count", count, 8);
        chk("fill_dp_ready", dp_ready, 0);
        chk("fill_dp_idx_wrap", dp_idx, 0);
        step();
        dp_valid = 1'b0;
        chk("fill_reject", count, 8);

        // Dual commit of idx0/idx1.
        wb_en    = 2'b11;
        wb_idx   = {3'd1, 3'd0};
        wb_value = {32'd7, 32'd5};
        step();
        wb_en = '0;
        #1;
        chk("dual_no_same_cycle", cm_en, 0);
        chk("dual_count_hold", count, 8);
        step();
        chk("dual_cm_en", cm_en, 2'b11);
        chk("dual_cm_value", cm_value, {32'd7, 32'd5});
        chk("dual_cm_idx", cm_idx, {3'd1, 3'd0});
        chk("dual_cm_rd", cm_rd, {6'd1, 6'd0});
        chk("dual_count", count, 6);
        chk("dual_dp_ready", dp_ready, 1);
        step();
        chk("dual_cm_idle", cm_en, 0);

        // Operand forwarding and port priority.
        qk_idx = 4'd6;
        #1;
        chk("fwd_qk_unready", qk_ready, 0);
        qj_idx   = 4'd3;
        qk_idx   = 4'd4;
        wb_en    = 2'b11;
        wb_idx   = {3'd4, 3'd3};
        wb_value = {32'h22, 32'hABCD};
        #1;
        chk("fwd_qj_ready", qj_ready, 1);
        chk("fwd_vj", vj, 32'hABCD);
        chk("fwd_qk_ready", qk_ready, 1);
        chk("fwd_vk", vk, 32'h22);
        step();
        wb_idx   = {3'd5, 3'd5};
        wb_value = {32'h44, 32'h33};
        qj_idx   = 4'd5;
        #1;
        chk("fwd_prio_vj", vj, 32'h44);
        step();
        wb_en = '0;
        #1;
        chk("stored_prio_ready", qj_ready, 1);
        chk("stored_prio_vj", vj, 32'h44);
        qj_idx = 4'd3;
        #1;
        chk("stored_vj3", vj, 32'hABCD);

        // Mispredicted branch followed by younger entries.
        do_reset();
        disp(7'd5, 32'h40, 6'h20, 1'b0);
        disp(7'd0, 32'h44, 6'd2, 1'b0);
        disp(7'd0, 32'h48, 6'd3, 1'b0);
        wb_en      = 2'b11;
        wb_idx     = {3'd1, 3'd0};
        wb_value   = {32'd9, 32'd1};
        wb_next_pc = {32'd0, 32'h100};
        step();
        wb_en     = '0;
        dp_valid  = 1'b1;
        dp_opcode = 7'd0;
        step();
        chk("mp_flush", flush, 1);
        chk("mp_flush_pc", flush_pc, 32'h100);
        chk("mp_bp_en", bp_en, 1);
        chk("mp_bp_pc", bp_pc, 32'h40);
        chk("mp_bp_taken", bp_taken, 1);
        chk("mp_cm_en_single", cm_en, 2'b01);
        chk("mp_count", count, 0);
        chk("mp_dp_ready", dp_ready, 0);
        chk("mp_dp_idx", dp_idx, 0);
        step();
        dp_valid = 1'b0;
        chk("mp_flush_done", flush, 0);
        chk("mp_bp_done", bp_en, 0);
        chk("mp_count_after", count, 0);

        // Correctly predicted taken branch: predictor update only.
        disp(7'd6, 32'h80, 6'h20, 1'b1);
        wb_en    = 2'b01;
        wb_idx   = {3'd0, 3'd0};
        wb_value = {32'd0, 32'd1};
        step();
        wb_en = '0;
        step();
        chk("bp_ok_en", bp_en, 1);
        chk("bp_ok_pc", bp_pc, 32'h80);
        chk("bp_ok_flush", flush, 0);
        chk("bp_ok_count", count, 0);

        // Store at head waits for st_ack.
        do_reset();
        disp(7'd16, 32'h200, 6'd3, 1'b0);
        disp(7'd0, 32'h204, 6'd2, 1'b0);
        wb_en    = 2'b01;
        wb_idx   = {3'd0, 3'd1};
        wb_value = {32'd0, 32'h55};
        #1;
        chk("st_req", st_req, 1);
        chk("st_idx", st_idx, 0);
        step();
        wb_en = '0;
        step();
        chk("st_hold_req", st_req, 1);
        chk("st_hold_cm", cm_en, 0);
        chk("st_hold_count", count, 2);
        st_ack = 1'b1;
        step();
        st_ack = 1'b0;
        #1;
        chk("st_ret_cm_en", cm_en, 2'b01);
        chk("st_ret_cm_idx", cm_idx[2:0], 0);
        chk("st_ret_cm_rd", cm_rd[5:0], 6'b100000);
        chk("st_ret_count", count, 1);
        chk("st_ret_req", st_req, 0);
        step();
        chk("st_next_cm_en", cm_en, 2'b01);
        chk("st_next_cm_idx", cm_idx[2:0], 1);
        chk("st_next_cm_val", cm_value[31:0], 32'h55);
        chk("st_next_cm_rd", cm_rd[5:0], 6'd2);
        chk("st_next_count", count, 0);

        // jalr flush, then reset in the flush cycle.
        do_reset();
        disp(7'd4, 32'h10, 6'd1, 1'b0);
        wb_en      = 2'b01;
        wb_idx     = '0;
        wb_next_pc = {32'd0, 32'h200};
        step();
        wb_en = '0;
        step();
        chk("jalr_flush", flush, 1);
        chk("jalr_flush_pc", flush_pc, 32'h200);
        chk("jalr_bp_en", bp_en, 0);
        chk("jalr_count", count, 0);
        Sys_rst = 1'b0;
        step();
        Sys_rst = 1'b1;
        chk("rstf_flush", flush, 0);
        chk("rstf_flush_pc", flush_pc, 0);
        chk("rstf_cm_en", cm_en, 0);
        chk("rstf_count", count, 0);

        // Reset on the edge that would have triggered the flush.
        disp(7'd4, 32'h10, 6'd1, 1'b0);
        wb_en      = 2'b01;
        wb_idx     = '0;
        wb_next_pc = {32'd0, 32'h300};
        step();
        wb_en   = '0;
        Sys_rst = 1'b0;
        step();
        Sys_rst = 1'b1;
        chk("rstc_flush", flush, 0);
        chk("rstc_flush_pc", flush_pc, 0);
        chk("rstc_cm_en", cm_en, 0);
        chk("rstc_count", count, 0);

        // Sys_rdy low holds state and suppresses commit.
        Sys_rdy   = 1'b0;
        dp_valid  = 1'b1;
        dp_opcode = 7'd0;
        step();
        dp_valid = 1'b0;
        chk("stall_no_dispatch", count, 0);
        Sys_rdy = 1'b1;
        disp(7'd0, 32'h20, 6'd4, 1'b0);
        wb_en    = 2'b01;
        wb_idx   = '0;
        wb_value = {32'd0, 32'h77};
        step();
        wb_en   = '0;
        Sys_rdy = 1'b0;
        step();
        chk("stall_cm_en", cm_en, 0);
        chk("stall_count", count, 1);
        Sys_rdy = 1'b1;
        step();
        chk("resume_cm_en", cm_en, 2'b01);
        chk("resume_cm_val", cm_value[31:0], 32'h77);
        chk("resume_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
